// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C target and its line filters.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_pkg;

    // Protocol states of the target; one state per byte phase plus its ACK slot.
    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        SUB,
        SUB_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK_WAIT
    } i2c_state_e;

    // Level on SDA during the ninth clock.
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // ADV7611 control map device addresses (7-bit).
    localparam logic [6:0] ADV7611_IO_ADDR   = 7'h4C;
    localparam logic [6:0] ADV7611_CP_ADDR   = 7'h22;
    localparam logic [6:0] ADV7611_HDMI_ADDR = 7'h34;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: synchronises one I2C line, rejects pulses shorter than FILT cycles, emits level and edges.
// Latency: 2 sync + FILT history + 1 register cycles from pin to lvl_o/rise_o/fall_o.
// Backpressure: none; free-running every clk_50 cycle.
module i2c_line_filter #(
    parameter int FILT = 3
) (
    input  logic clk_50,
    input  logic reset,
    input  logic line_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0]      sync_q;
    logic [FILT-1:0] hist_q;
    logic            lvl_q;
    logic            lvl_d;
    logic            rise_q;
    logic            fall_q;

    // The filtered level only moves once the whole history window agrees.
    always_comb begin
        lvl_d = lvl_q;
        if (&hist_q) begin
            lvl_d = 1'b1;
        end else if (~|hist_q) begin
            lvl_d = 1'b0;
        end
    end

    // Synchroniser, history window, filtered level and single-cycle edge strobes.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            sync_q <= 2'b11;
            hist_q <= '1;
            lvl_q  <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            hist_q <= FILT'({hist_q, sync_q[1]});
            lvl_q  <= lvl_d;
            rise_q <= lvl_d & ~lvl_q;
            fall_q <= ~lvl_d & lvl_q;
        end
    end

    assign lvl_o  = lvl_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C responder with an internal 8-bit register map, host read port and write-notify strobe.
// Latency: host_rdata 1 cycle after host_addr; wr_strobe the cycle after the 8th SCL rise of a data byte.
// Backpressure: none; never stretches SCL. Macro I2C_TARGET_AUTOINC_EN enables pointer auto-increment.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = ADV7611_IO_ADDR,
    parameter int         DEPTH    = 256,
    parameter int         FILT     = 3
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] host_addr,
    output logic [7:0] host_rdata,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int         AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] PMASK = 8'(DEPTH - 1);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILT(FILT)) u_scl_filt (
        .clk_50 (clk_50),
        .reset  (reset),
        .line_i (SCL),
        .lvl_o  (scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_filter #(.FILT(FILT)) u_sda_filt (
        .clk_50 (clk_50),
        .reset  (reset),
        .line_i (SDA),
        .lvl_o  (sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    logic start_evt;
    logic stop_evt;
    assign start_evt = sda_fall & scl_lvl;
    assign stop_evt  = sda_rise & scl_lvl;

    i2c_state_e  state_q;
    logic [3:0]  bitcnt_q;
    logic [7:0]  shreg_q;
    logic [7:0]  ptr_q;
    logic        rw_q;
    logic        sda_oe_q;
    logic        busy_q;
    logic        wr_strobe_q;
    logic [7:0]  wr_addr_q;
    logic [7:0]  wr_data_q;
    logic [7:0]  host_rdata_q;
    logic [7:0]  mem_q [DEPTH];

    logic [7:0] shift_in;
    logic [7:0] mem_rd;
    assign shift_in = {shreg_q[6:0], sda_lvl};
    assign mem_rd   = mem_q[ptr_q[AW-1:0]];

    // Protocol FSM: START/STOP override everything, otherwise act on filtered SCL edges.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (start_evt) begin
                state_q  <= ADDR;
                bitcnt_q <= '0;
                sda_oe_q <= 1'b0;
            end else if (stop_evt) begin
                state_q  <= IDLE;
                bitcnt_q <= '0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    ADDR: begin
                        if (scl_rise) begin
                            shreg_q  <= shift_in;
                            bitcnt_q <= bitcnt_q + 4'd1;
                        end else if (scl_fall && bitcnt_q == 4'd8) begin
                            if (shreg_q[7:1] == DEV_ADDR) begin
                                sda_oe_q <= 1'b1;
                                busy_q   <= 1'b1;
                                rw_q     <= shreg_q[0];
                                state_q  <= ADDR_ACK;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw_q) begin
                                // First read bit goes out on the same fall that ends the ACK.
                                sda_oe_q <= ~mem_rd[7];
                                shreg_q  <= {mem_rd[6:0], 1'b0};
                                bitcnt_q <= 4'd1;
                                state_q  <= RDATA;
                            end else begin
                                sda_oe_q <= 1'b0;
                                bitcnt_q <= '0;
                                state_q  <= SUB;
                            end
                        end
                    end
                    SUB: begin
                        if (scl_rise) begin
                            shreg_q  <= shift_in;
                            bitcnt_q <= bitcnt_q + 4'd1;
                        end else if (scl_fall && bitcnt_q == 4'd8) begin
                            ptr_q    <= shreg_q & PMASK;
                            sda_oe_q <= 1'b1;
                            state_q  <= SUB_ACK;
                        end
                    end
                    SUB_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                            bitcnt_q <= '0;
                            state_q  <= WDATA;
                        end
                    end
                    WDATA: begin
                        if (scl_rise) begin
                            shreg_q  <= shift_in;
                            bitcnt_q <= bitcnt_q + 4'd1;
                            if (bitcnt_q == 4'd7) begin
                                wr_strobe_q <= 1'b1;
                                wr_addr_q   <= ptr_q;
                                wr_data_q   <= shift_in;
`ifdef I2C_TARGET_AUTOINC_EN
                                ptr_q       <= (ptr_q + 8'd1) & PMASK;
`endif
                            end
                        end else if (scl_fall && bitcnt_q == 4'd8) begin
                            sda_oe_q <= 1'b1;
                            state_q  <= WDATA_ACK;
                        end
                    end
                    RDATA: begin
                        // bitcnt 1..8: bits on the wire, 9: awaiting master ACK, 10: ACKed, reload.
                        if (scl_fall) begin
                            if (bitcnt_q < 4'd8) begin
                                sda_oe_q <= ~shreg_q[7];
                                shreg_q  <= {shreg_q[6:0], 1'b0};
                                bitcnt_q <= bitcnt_q + 4'd1;
                            end else if (bitcnt_q == 4'd8) begin
                                sda_oe_q <= 1'b0;
                                bitcnt_q <= 4'd9;
`ifdef I2C_TARGET_AUTOINC_EN
                                ptr_q    <= (ptr_q + 8'd1) & PMASK;
`endif
                            end else if (bitcnt_q == 4'd10) begin
                                sda_oe_q <= ~mem_rd[7];
                                shreg_q  <= {mem_rd[6:0], 1'b0};
                                bitcnt_q <= 4'd1;
                            end
                        end else if (scl_rise && bitcnt_q == 4'd9) begin
                            if (sda_lvl == I2C_ACK) begin
                                bitcnt_q <= 4'd10;
                            end else begin
                                state_q <= RACK_WAIT;
                            end
                        end
                    end
                    RACK_WAIT: begin
                        sda_oe_q <= 1'b0;
                    end
                    IDLE: begin
                        sda_oe_q <= 1'b0;
                    end
                    default: begin
                        state_q  <= IDLE;
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Register array: committed from the registered write beat, cleared by reset.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_strobe_q) begin
            mem_q[wr_addr_q[AW-1:0]] <= wr_data_q;
        end
    end

    // Host read port: a same-cycle write is seen on the following read.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            host_rdata_q <= '0;
        end else begin
            host_rdata_q <= mem_q[host_addr[AW-1:0]];
        end
    end

    // Open-drain pad: reset releases the line without waiting for the next edge.
    assign SDA = (sda_oe_q && !reset) ? 1'b0 : 1'bz;

    assign host_rdata = host_rdata_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;

endmodule
